mod_cfg_ctrl: RTL and testbench
===============================

// Module: mod_cfg_ctrl
// PURPOSE
//  Control front-end for the complete modulator datapath. Generates the datapath sample strobe at a
//  programmable rate and holds the modulation configuration in shadow registers. New settings are
//  applied atomically on a sample boundary. The datapath is held in reset for a flush window when the
//  FM/AM mode or the modulating source changes, so comp/CIC/DDS state never mixes the old and new modes.
// PARAMETERS
//  DIV_W     16  width of the sample-rate divider ratio
//  FLUSH_LEN 32  number of strobes dp_rst is held after a structural change (>=1)
// PORTS
//  clk           in  1      system clock
//  rst           in  1      asynchronous, active-high reset
//  run           in  1      1 = generate strobes, 0 = idle/hold
//  div_ratio     in  DIV_W  strobe period in clk cycles; 0 and 1 both mean every cycle
//  cfg_wr        in  1      load request; accepted only when cfg_ready=1
//  cfg_ready     out 1      shadow register free
//  cfg_fm_am     in  1      requested mode (0 = AM, 1 = FM)
//  cfg_source    in  2      requested source (0 = sin, 1 = ramp, 2 = sqr, 3 = external)
//  cfg_comp_dac  in  1      requested DAC compensation select
//  cfg_frec_mod  in  24     requested modulating DDS increment
//  cfg_frec_por  in  24     requested carrier increment
//  cfg_im_am     in  16     requested AM index
//  cfg_im_fm     in  16     requested FM index
//  dp_val_in     out 1      one-cycle sample strobe to datapath
//  dp_rst        out 1      datapath reset
//  dp_c_fm_am, dp_c_source, dp_c_comp_dac, dp_frec_mod, dp_frec_por, dp_im_am, dp_im_fm
//                out 1/2/1/24/24/16/16  active configuration, registered
//  upd_done      out 1      one-cycle pulse: last accepted config now in effect, flush finished
//  cfg_err       out 1      one-cycle pulse: cfg_wr while cfg_ready=0 (request dropped)
// BEHAVIOUR
//  Reset values:
//   - state IDLE; dp_rst=1; dp_val_in=0; all dp_* config outputs 0; cfg_ready=1; upd_done=0; cfg_err=0.
//  FSM states: IDLE, RUN, PEND, FLUSH.
//  IDLE:
//   - dp_rst=1, dp_val_in=0, divider count cleared.
//   - cfg_wr: applied to dp_* on the next edge; upd_done pulses one cycle later. No flush.
//   - run=1: latch div_ratio; go to RUN; dp_rst=0 on the same edge.
//  Divider:
//   - cnt counts 0..R-1, where R=max(div_ratio,1). tick = (cnt==R-1).
//   - dp_val_in is registered from tick, so strobes are exactly R cycles apart.
//   - The first strobe occurs R cycles after entering RUN.
//  RUN:
//   - cfg_wr && cfg_ready: capture all cfg_* into shadow; go to PEND; cfg_ready=0 the next cycle.
//  PEND:
//   - On tick: dp_* <= shadow, on the same edge dp_val_in rises. The new config therefore coincides
//     exactly with its first strobe. Worst-case apply latency is R cycles.
//   - If fm_am or source differ from the active values: go to FLUSH with dp_rst=1 from that edge.
//   - Otherwise go to RUN and pulse upd_done.
//  FLUSH:
//   - Strobes continue; count FLUSH_LEN strobes.
//   - On the edge after the FLUSH_LEN-th strobe: dp_rst=0, go to RUN, pulse upd_done.
//  cfg_ready=1 only in IDLE and RUN.
//  run=0 in any non-IDLE state: go to IDLE next edge. Any pending shadow is applied on that edge and
//   upd_done pulses. An in-progress flush is abandoned (IDLE keeps dp_rst=1 anyway).
//  Simultaneous cfg_wr and run falling in RUN: capture, then apply in IDLE. Nothing is lost.
//  div_ratio changes while running are ignored until the next IDLE->RUN transition.
//  rst mid-operation: immediate return to reset values. Shadow contents are discarded.
//  All config outputs change only on the apply edge; they never glitch between strobes.
// STRUCTURE
//  - mod_ctrl_defs.vh: state encodings, source codes (SRC_SIN/RAMP/SQR/EXT), config field widths.
//  - One sub-module, strobe_div: counter, tick, registered strobe; inputs en and ratio.
//  - Top level holds the FSM, shadow/active registers and the flush counter
//    (width $clog2(FLUSH_LEN+1)).
// TESTING
//  1. rst; run=1, div_ratio=4 -> dp_rst falls; dp_val_in pulses on cycles 4, 8, 12...
//     after run, always 1 cycle wide.
//  2. In RUN, write frec_por=0x100000 only -> dp_frec_por changes on the edge dp_val_in rises;
//     no dp_rst; upd_done pulses.
//  3. Write with fm_am 0->1, FLUSH_LEN=32 -> dp_rst=1 for exactly 32 strobes then 0;
//     upd_done after the flush; cfg_ready=0 throughout.
//  4. cfg_wr during PEND -> cfg_err pulse; active/shadow config unchanged.
//  5. Drop run during FLUSH with shadow pending -> IDLE next edge; dp_val_in=0; dp_rst=1;
//     config applied; upd_done pulses.
//  6. div_ratio=0 -> strobe every cycle; assert rst mid-FLUSH -> all outputs return to reset values.

Source files
------------

// File: rtl/mod_cfg_ctrl_pkg.sv
// Shared types for the modulator control front-end: FSM states, source codes
// and the packed configuration record held in the shadow and active registers.
package mod_cfg_ctrl_pkg;

    localparam int unsigned FREC_W = 24;
    localparam int unsigned IM_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        SRC_SIN  = 2'd0,
        SRC_RAMP = 2'd1,
        SRC_SQR  = 2'd2,
        SRC_EXT  = 2'd3
    } src_t;

    typedef struct packed {
        logic              fm_am;
        src_t              source;
        logic              comp_dac;
        logic [FREC_W-1:0] frec_mod;
        logic [FREC_W-1:0] frec_por;
        logic [IM_W-1:0]   im_am;
        logic [IM_W-1:0]   im_fm;
    } cfg_t;

    // A mode or source change restructures the datapath and needs a flush.
    function automatic logic needs_flush(input cfg_t next_cfg, input cfg_t cur_cfg);
        return (next_cfg.fm_am != cur_cfg.fm_am) || (next_cfg.source != cur_cfg.source);
    endfunction

endpackage

// File: rtl/mod_cfg_ctrl_strobe_div.sv
// Programmable sample-rate divider: free-running count 0..R-1 while enabled,
// with a registered one-cycle strobe on every wrap (R = max(ratio,1)).
module strobe_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick,
    output logic             strobe
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    always_comb begin
        last = (ratio == '0) ? '0 : ratio - 1'b1;
        tick = en && (cnt == last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= tick;
            cnt    <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod_cfg_ctrl.sv
// Modulator control front-end: sample strobe generation, shadowed configuration
// applied on a sample boundary, and datapath flush on mode/source changes.
module mod_cfg_ctrl
    import mod_cfg_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned FLUSH_LEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             cfg_wr,
    output logic             cfg_ready,
    input  logic             cfg_fm_am,
    input  logic [1:0]       cfg_source,
    input  logic             cfg_comp_dac,
    input  logic [23:0]      cfg_frec_mod,
    input  logic [23:0]      cfg_frec_por,
    input  logic [15:0]      cfg_im_am,
    input  logic [15:0]      cfg_im_fm,
    output logic             dp_val_in,
    output logic             dp_rst,
    output logic             dp_c_fm_am,
    output logic [1:0]       dp_c_source,
    output logic             dp_c_comp_dac,
    output logic [23:0]      dp_frec_mod,
    output logic [23:0]      dp_frec_por,
    output logic [15:0]      dp_im_am,
    output logic [15:0]      dp_im_fm,
    output logic             upd_done,
    output logic             cfg_err
);

    localparam int unsigned      FC_W    = $clog2(FLUSH_LEN + 1);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_LEN - 1);

    state_t           state_q, state_d;
    cfg_t             cfg_in, shadow, active;
    logic [DIV_W-1:0] ratio_q;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             tick, div_en;
    logic             capture, ld_in, ld_sh;
    logic             dp_rst_d, upd_d;
    logic             sh_pend, sh_pend_d, upd_pend, upd_pend_d;

    always_comb begin
        cfg_in.fm_am    = cfg_fm_am;
        cfg_in.source   = src_t'(cfg_source);
        cfg_in.comp_dac = cfg_comp_dac;
        cfg_in.frec_mod = cfg_frec_mod;
        cfg_in.frec_por = cfg_frec_por;
        cfg_in.im_am    = cfg_im_am;
        cfg_in.im_fm    = cfg_im_fm;
    end

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    // Gating with run clears the strobe on the edge that returns to IDLE.
    assign div_en    = run && (state_q != ST_IDLE);

    strobe_div #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en     (div_en),
        .ratio  (ratio_q),
        .tick   (tick),
        .strobe (dp_val_in)
    );

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        ld_in      = 1'b0;
        ld_sh      = 1'b0;
        dp_rst_d   = dp_rst;
        upd_d      = upd_pend;
        sh_pend_d  = sh_pend;
        upd_pend_d = 1'b0;
        fcnt_d     = fcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                dp_rst_d = 1'b1;
                // A direct write wins over a shadow left by the run-drop edge.
                if (cfg_wr) begin
                    ld_in      = 1'b1;
                    upd_pend_d = 1'b1;
                    sh_pend_d  = 1'b0;
                end else if (sh_pend) begin
                    ld_sh     = 1'b1;
                    upd_d     = 1'b1;
                    sh_pend_d = 1'b0;
                end
                if (run) begin
                    state_d  = ST_RUN;
                    dp_rst_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d  = ST_IDLE;
                    dp_rst_d = 1'b1;
                    if (cfg_wr) begin
                        capture   = 1'b1;
                        sh_pend_d = 1'b1;
                    end
                end else if (cfg_wr) begin
                    capture = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!run) begin
                    state_d  = ST_IDLE;
                    dp_rst_d = 1'b1;
                    ld_sh    = 1'b1;
                    upd_d    = 1'b1;
                end else if (tick) begin
                    ld_sh = 1'b1;
                    if (needs_flush(shadow, active)) begin
                        state_d  = ST_FLUSH;
                        dp_rst_d = 1'b1;
                        fcnt_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                        upd_d   = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (!run) begin
                    state_d  = ST_IDLE;
                    dp_rst_d = 1'b1;
                    upd_d    = 1'b1;
                end else if (dp_val_in) begin
                    if (fcnt_q == FC_LAST) begin
                        state_d  = ST_RUN;
                        dp_rst_d = 1'b0;
                        upd_d    = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= '0;
            shadow   <= '0;
            ratio_q  <= '0;
            fcnt_q   <= '0;
            dp_rst   <= 1'b1;
            upd_done <= 1'b0;
            cfg_err  <= 1'b0;
            sh_pend  <= 1'b0;
            upd_pend <= 1'b0;
        end else begin
            fcnt_q   <= fcnt_d;
            dp_rst   <= dp_rst_d;
            upd_done <= upd_d;
            cfg_err  <= cfg_wr && !cfg_ready;
            sh_pend  <= sh_pend_d;
            upd_pend <= upd_pend_d;
            if (capture) shadow <= cfg_in;
            if (ld_in)      active <= cfg_in;
            else if (ld_sh) active <= shadow;
            if ((state_q == ST_IDLE) && run) ratio_q <= div_ratio;
        end
    end

    assign dp_c_fm_am    = active.fm_am;
    assign dp_c_source   = active.source;
    assign dp_c_comp_dac = active.comp_dac;
    assign dp_frec_mod   = active.frec_mod;
    assign dp_frec_por   = active.frec_por;
    assign dp_im_am      = active.im_am;
    assign dp_im_fm      = active.im_fm;

endmodule

// File: tb/tb_mod_cfg_ctrl.sv
// Self-checking bench for mod_cfg_ctrl: directed scenarios plus random traffic
// compared every cycle against an event-level reference model.
module tb_mod_cfg_ctrl;

    localparam int FLUSH_LEN = 32;
    // Config vector layout: fm_am[83] source[82:81] comp_dac[80]
    // frec_mod[79:56] frec_por[55:32] im_am[31:16] im_fm[15:0]
    localparam logic [88:0] RESET_OUT = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 84'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] div_ratio = '0;
    logic        cfg_wr = 1'b0;
    logic        cfg_ready;
    logic        cfg_fm_am = 1'b0;
    logic [1:0]  cfg_source = '0;
    logic        cfg_comp_dac = 1'b0;
    logic [23:0] cfg_frec_mod = '0, cfg_frec_por = '0;
    logic [15:0] cfg_im_am = '0, cfg_im_fm = '0;
    logic        dp_val_in, dp_rst, dp_c_fm_am, dp_c_comp_dac, upd_done, cfg_err;
    logic [1:0]  dp_c_source;
    logic [23:0] dp_frec_mod, dp_frec_por;
    logic [15:0] dp_im_am, dp_im_fm;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mod_cfg_ctrl #(.DIV_W(16), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk(clk), .rst(rst), .run(run), .div_ratio(div_ratio),
        .cfg_wr(cfg_wr), .cfg_ready(cfg_ready),
        .cfg_fm_am(cfg_fm_am), .cfg_source(cfg_source), .cfg_comp_dac(cfg_comp_dac),
        .cfg_frec_mod(cfg_frec_mod), .cfg_frec_por(cfg_frec_por),
        .cfg_im_am(cfg_im_am), .cfg_im_fm(cfg_im_fm),
        .dp_val_in(dp_val_in), .dp_rst(dp_rst),
        .dp_c_fm_am(dp_c_fm_am), .dp_c_source(dp_c_source), .dp_c_comp_dac(dp_c_comp_dac),
        .dp_frec_mod(dp_frec_mod), .dp_frec_por(dp_frec_por),
        .dp_im_am(dp_im_am), .dp_im_fm(dp_im_fm),
        .upd_done(upd_done), .cfg_err(cfg_err)
    );

    logic [83:0] in_vec, dut_cfg;
    logic [88:0] dut_out, m_out;
    assign in_vec  = {cfg_fm_am, cfg_source, cfg_comp_dac, cfg_frec_mod, cfg_frec_por, cfg_im_am, cfg_im_fm};
    assign dut_cfg = {dp_c_fm_am, dp_c_source, dp_c_comp_dac, dp_frec_mod, dp_frec_por, dp_im_am, dp_im_fm};
    assign dut_out = {dp_rst, dp_val_in, cfg_ready, upd_done, cfg_err, dut_cfg};

    // Reference model: run phase counted in cycles, flush as strobes remaining.
    logic        m_running, m_pending, m_sh_idle, m_later;
    logic        m_rst, m_val, m_upd, m_err, m_ready, m_hit;
    int          m_phase, m_R, m_flush_left;
    logic [83:0] m_act, m_sh;

    assign m_ready = !m_running || (!m_pending && m_flush_left == 0);
    assign m_hit   = ((m_phase + 1) % m_R) == 0;
    assign m_out   = {m_rst, m_val, m_ready, m_upd, m_err, m_act};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running <= 1'b0; m_pending <= 1'b0; m_sh_idle <= 1'b0; m_later <= 1'b0;
            m_rst <= 1'b1; m_val <= 1'b0; m_upd <= 1'b0; m_err <= 1'b0;
            m_phase <= 0; m_R <= 1; m_flush_left <= 0; m_act <= '0; m_sh <= '0;
        end else begin
            m_err   <= cfg_wr && !m_ready;
            m_upd   <= m_later;
            m_later <= 1'b0;
            m_val   <= 1'b0;
            if (!m_running) begin
                m_rst <= 1'b1;
                if (cfg_wr) begin
                    m_act <= in_vec; m_later <= 1'b1; m_sh_idle <= 1'b0;
                end else if (m_sh_idle) begin
                    m_act <= m_sh; m_upd <= 1'b1; m_sh_idle <= 1'b0;
                end
                if (run) begin
                    m_running <= 1'b1; m_phase <= 0; m_rst <= 1'b0;
                    m_R <= (div_ratio == 0) ? 1 : int'(div_ratio);
                end
            end else if (!run) begin
                m_running <= 1'b0; m_rst <= 1'b1;
                if (m_pending) begin
                    m_act <= m_sh; m_upd <= 1'b1; m_pending <= 1'b0;
                end else if (m_flush_left > 0) begin
                    m_upd <= 1'b1; m_flush_left <= 0;
                end else if (cfg_wr) begin
                    m_sh <= in_vec; m_sh_idle <= 1'b1;
                end
            end else begin
                m_phase <= m_phase + 1;
                m_val   <= m_hit;
                if (m_pending) begin
                    if (m_hit) begin
                        m_act <= m_sh; m_pending <= 1'b0;
                        if (m_sh[83] != m_act[83] || m_sh[82:81] != m_act[82:81]) begin
                            m_flush_left <= FLUSH_LEN; m_rst <= 1'b1;
                        end else begin
                            m_upd <= 1'b1;
                        end
                    end
                end else if (m_flush_left > 0) begin
                    if (m_val) begin
                        if (m_flush_left == 1) begin
                            m_flush_left <= 0; m_rst <= 1'b0; m_upd <= 1'b1;
                        end else begin
                            m_flush_left <= m_flush_left - 1;
                        end
                    end
                end else if (cfg_wr) begin
                    m_sh <= in_vec; m_pending <= 1'b1;
                end
            end
        end
    end

    task automatic set_cfg(input logic [83:0] v);
        {cfg_fm_am, cfg_source, cfg_comp_dac, cfg_frec_mod, cfg_frec_por, cfg_im_am, cfg_im_fm} = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; cfg_wr = 1'b0; set_cfg('0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_errors++; $display("FAIL reset_values: got %h expected %h", dut_out, RESET_OUT);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_errors++; $display("FAIL idle_after_reset: got %h expected %h", dut_out, RESET_OUT);
        end
    endtask

    task automatic test_strobe();
        div_ratio = 16'd4; run = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            n_checks++;
            if (dp_val_in !== ((k > 0) && (k % 4 == 0))) begin
                n_errors++; $display("FAIL strobe_r4 k=%0d: got %b expected %b", k, dp_val_in, (k > 0) && (k % 4 == 0));
            end
            n_checks++;
            if (dp_rst !== 1'b0) begin
                n_errors++; $display("FAIL strobe_dp_rst k=%0d: got %b expected 0", k, dp_rst);
            end
            n_checks++;
            if (dut_out !== m_out) begin
                n_errors++; $display("FAIL strobe_model k=%0d: got %h expected %h", k, dut_out, m_out);
            end
        end
    endtask

    task automatic test_apply();
        logic [83:0] v;
        logic changed;
        v = '0; v[55:32] = 24'h100000;
        set_cfg(v); cfg_wr = 1'b1;
        changed = 1'b0;
        for (int i = 0; i < 20 && !changed; i++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            n_checks++;
            if (dut_out !== m_out) begin
                n_errors++; $display("FAIL apply_model i=%0d: got %h expected %h", i, dut_out, m_out);
            end
            n_checks++;
            if (dp_rst !== 1'b0) begin
                n_errors++; $display("FAIL apply_no_flush i=%0d: got dp_rst %b expected 0", i, dp_rst);
            end
            if (dp_frec_por === 24'h100000) begin
                changed = 1'b1;
                n_checks++;
                if ({dp_val_in, upd_done} !== 2'b11) begin
                    n_errors++; $display("FAIL apply_on_strobe: got val/upd %b%b expected 11", dp_val_in, upd_done);
                end
            end
        end
        n_checks++;
        if (!changed) begin
            n_errors++; $display("FAIL apply_timeout: frec_por %h expected 100000", dp_frec_por);
        end
    endtask

    task automatic test_flush();
        logic [83:0] v;
        int strobes;
        logic done;
        v = '0; v[55:32] = 24'h100000; v[83] = 1'b1;
        set_cfg(v); cfg_wr = 1'b1;
        strobes = 0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            n_checks++;
            if (dut_out !== m_out) begin
                n_errors++; $display("FAIL flush_model i=%0d: got %h expected %h", i, dut_out, m_out);
            end
            if (upd_done === 1'b1) begin
                done = 1'b1;
                n_checks++;
                if (dp_rst !== 1'b0) begin
                    n_errors++; $display("FAIL flush_end_rst: got %b expected 0", dp_rst);
                end
            end else begin
                if (dp_rst === 1'b1 && dp_val_in === 1'b1) strobes++;
                n_checks++;
                if (cfg_ready !== 1'b0) begin
                    n_errors++; $display("FAIL flush_ready i=%0d: got %b expected 0", i, cfg_ready);
                end
            end
        end
        n_checks++;
        if (!done || strobes != FLUSH_LEN) begin
            n_errors++; $display("FAIL flush_len: got %0d strobes (done=%b) expected %0d", strobes, done, FLUSH_LEN);
        end
    endtask

    task automatic test_cfg_err();
        logic [83:0] v1, v2;
        logic [23:0] r1;
        logic seen;
        r1 = 24'($urandom_range(1, 24'hfffffe));
        v1 = '0; v1[83] = 1'b1; v1[55:32] = 24'h100000; v1[79:56] = r1;
        v2 = v1; v2[79:56] = ~r1; v2[83] = 1'b0;
        set_cfg(v1); cfg_wr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_errors++; $display("FAIL err_pend_ready: got %b expected 0", cfg_ready);
        end
        set_cfg(v2);
        @(negedge clk);
        cfg_wr = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_errors++; $display("FAIL err_pulse: got %b expected 1", cfg_err);
        end
        seen = upd_done;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out) begin
                n_errors++; $display("FAIL err_model i=%0d: got %h expected %h", i, dut_out, m_out);
            end
            seen = upd_done;
        end
        n_checks++;
        if (!seen || dut_cfg !== v1) begin
            n_errors++; $display("FAIL err_cfg_kept: got %h expected %h (upd seen %b)", dut_cfg, v1, seen);
        end
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_errors++; $display("FAIL err_one_cycle: got %b expected 0", cfg_err);
        end
    endtask

    task automatic test_drop_in_flush();
        logic [83:0] v;
        logic flushing;
        v = dut_cfg; v[82:81] = 2'd2;
        set_cfg(v); cfg_wr = 1'b1;
        flushing = 1'b0;
        for (int i = 0; i < 20 && !flushing; i++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            flushing = (dp_rst === 1'b1);
        end
        n_checks++;
        if (!flushing) begin
            n_errors++; $display("FAIL drop_flush_start: got dp_rst %b expected 1", dp_rst);
        end
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dp_val_in, dp_rst, upd_done} !== 3'b011 || dut_cfg !== v) begin
            n_errors++; $display("FAIL drop_flush: got val/rst/upd %b%b%b cfg %h expected 011 cfg %h",
                                 dp_val_in, dp_rst, upd_done, dut_cfg, v);
        end
        @(negedge clk);
        n_checks++;
        if (dut_out !== m_out || upd_done !== 1'b0) begin
            n_errors++; $display("FAIL drop_flush_idle: got %h expected %h", dut_out, m_out);
        end
    endtask

    task automatic test_ratio0_rst();
        logic [83:0] v;
        div_ratio = 16'd0; run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (dp_val_in !== (k > 0)) begin
                n_errors++; $display("FAIL ratio0 k=%0d: got %b expected %b", k, dp_val_in, k > 0);
            end
        end
        v = dut_cfg; v[83] = ~v[83];
        set_cfg(v); cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (dp_rst !== 1'b1) begin
            n_errors++; $display("FAIL ratio0_flush: got dp_rst %b expected 1", dp_rst);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_errors++; $display("FAIL rst_mid_flush: got %h expected %h", dut_out, RESET_OUT);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out) begin
                n_errors++; $display("FAIL random i=%0d: got %h expected %h", i, dut_out, m_out);
            end
            rst          = ($urandom_range(0, 599) == 0);
            run          = ($urandom_range(0, 99) != 0);
            div_ratio    = 16'($urandom_range(0, 5));
            cfg_wr       = ($urandom_range(0, 5) == 0);
            cfg_fm_am    = 1'($urandom_range(0, 1));
            cfg_source   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            cfg_comp_dac = 1'($urandom_range(0, 1));
            cfg_frec_mod = 24'($urandom());
            cfg_frec_por = 24'($urandom());
            cfg_im_am    = 16'($urandom());
            cfg_im_fm    = 16'($urandom());
        end
        rst = 1'b0; cfg_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_apply();
        test_flush();
        test_cfg_err();
        test_drop_in_flush();
        test_ratio0_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
